seq_divider: RTL and testbench

//  Sequential restoring divider: the inverse of the BW x BW multiplier TOP
//  (y = a*b). Takes a 2*BW-bit product-width dividend and a BW-bit divisor and

---
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*BW-bit dividend / BW-bit divisor, one quotient bit per clock.
// Optional overflow detection is enabled by defining SEQ_DIV_OVF_EN.
module seq_divider #(
   parameter int unsigned BW = 4
) (
   input  logic            CLK,
   input  logic            RESETn,
   input  logic            start,
   input  logic [2*BW-1:0] dividend,
   input  logic [BW-1:0]   divisor,
   output logic [BW-1:0]   quotient,
   output logic [BW-1:0]   remainder,
   output logic            busy,
   output logic            done,
   output logic            div_by_zero,
   output logic            overflow
);

   localparam int unsigned CntW = (2 * BW > 1) ? $clog2(2 * BW) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(2 * BW - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e          state_q, state_d;
   logic [2*BW-1:0] shreg_q, shreg_d;
   logic [BW-1:0]   dvsr_q, dvsr_d;
   logic [BW-1:0]   prem_q, prem_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [BW-1:0]   quot_q, quot_d;
   logic [BW-1:0]   rem_q, rem_d;
   logic            dbz_q, dbz_d;
   logic            ovf_sel;

   logic [BW:0]     trial;
   logic [BW-1:0]   sub;
   logic            fits;
   logic [BW-1:0]   step_rem;

   // Partial remainder stays below the divisor, so the BW-bit modular difference is exact.
   always_comb begin
      trial    = {prem_q, shreg_q[2*BW-1]};
      fits     = trial >= {1'b0, dvsr_q};
      sub      = trial[BW-1:0] - dvsr_q;
      step_rem = fits ? sub : trial[BW-1:0];
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      dvsr_d  = dvsr_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  state_d = StDone;
                  dbz_d   = 1'b1;
                  quot_d  = '1;
                  rem_d   = dividend[BW-1:0];
               end else begin
                  state_d = StCalc;
                  shreg_d = dividend;
                  dvsr_d  = divisor;
                  prem_d  = '0;
                  cnt_d   = '0;
               end
            end
         end
         StCalc: begin
            // Dividend bits shift out the top while quotient bits shift in at the bottom.
            shreg_d = {shreg_q[2*BW-2:0], fits};
            prem_d  = step_rem;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               state_d = StDone;
               quot_d  = ovf_sel ? '1 : {shreg_q[BW-2:0], fits};
               rem_d   = step_rem;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= StIdle;
         shreg_q <= '0;
         dvsr_q  <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         dvsr_q  <= dvsr_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

`ifdef SEQ_DIV_OVF_EN
   logic ovf_pend_q, ovf_q;

   // Overflow is decided from the operands at start and reported together with done.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (state_q == StIdle && start) begin
         ovf_pend_q <= (divisor != '0) && (dividend[2*BW-1:BW] >= divisor);
         ovf_q      <= 1'b0;
      end else if (state_q == StCalc && cnt_q == CntLast) begin
         ovf_q <= ovf_pend_q;
      end
   end

   assign ovf_sel  = ovf_pend_q;
   assign overflow = ovf_q;
`else
   assign ovf_sel  = 1'b0;
   assign overflow = 1'b0;
`endif

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (BW=4): stimulus pushes expected results, a monitor checks
// each done pulse.
module tb_seq_divider;

   localparam int unsigned BW = 4;

   typedef struct {
      logic [BW-1:0] q;
      logic [BW-1:0] r;
      logic          dbz;
      logic          ovf;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [2*BW-1:0] dividend;
   logic [BW-1:0]   divisor;
   logic [BW-1:0]   quotient;
   logic [BW-1:0]   remainder;
   logic            busy;
   logic            done;
   logic            div_by_zero;
   logic            overflow;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_done = 1'b0;

   seq_divider #(.BW(BW)) dut (
      .CLK        (clk),
      .RESETn     (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .quotient   (quotient),
      .remainder  (remainder),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .overflow   (overflow)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every done pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (prev_done) chk("done_one_cycle", 1, 0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", int'(quotient), int'(e.q));
            chk("remainder", int'(remainder), int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
            chk("overflow", int'(overflow), int'(e.ovf));
         end
      end
      prev_done = rst_n && done;
   end

   // Issue one division and wait for done; exp_edges counts the accepting edge as the first.
   task automatic do_div(input logic [2*BW-1:0] dvd, input logic [BW-1:0] dvs,
                         input logic [BW-1:0] q, input logic [BW-1:0] r, input logic dbz,
                         input logic ovf, input int exp_edges, input bit poke);
      exp_t e;
      int   k;
      e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
      @(negedge clk);
      start    = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      sb.push_back(e);
      @(posedge clk);
      k = 1;
      @(negedge clk);
      start    = 1'b0;
      dividend = ~dvd;
      divisor  = ~dvs;
      chk("busy_after_start", int'(busy), 1);
      while (!done && k < 30) begin
         if (poke && k == 3) begin
            start    = 1'b1;
            dividend = 8'h11;
            divisor  = 4'h1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("latency_edges", k, exp_edges);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #20;
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_dbz", int'(div_by_zero), 0);
      chk("rst_ovf", int'(overflow), 0);
      #15 rst_n = 1'b1;

      do_div(8'h42, 4'hB, 4'h6, 4'h0, 1'b0, 1'b0, 9, 1'b0);
      do_div(8'h54, 4'hC, 4'h7, 4'h0, 1'b0, 1'b0, 9, 1'b0);
      do_div(8'h68, 4'hD, 4'h8, 4'h0, 1'b0, 1'b0, 9, 1'b0);
      do_div(8'h7E, 4'hE, 4'h9, 4'h0, 1'b0, 1'b0, 9, 1'b0);
      do_div(8'h96, 4'hF, 4'hA, 4'h0, 1'b0, 1'b0, 9, 1'b0);
      do_div(8'h64, 4'h7, 4'hE, 4'h2, 1'b0, 1'b0, 9, 1'b1);
      repeat (3) @(negedge clk);
      chk("hold_quotient", int'(quotient), 'hE);
      chk("hold_busy", int'(busy), 0);
      do_div(8'h42, 4'h0, 4'hF, 4'h2, 1'b1, 1'b0, 1, 1'b0);
`ifdef SEQ_DIV_OVF_EN
      do_div(8'hF0, 4'h3, 4'hF, 4'h0, 1'b0, 1'b1, 9, 1'b0);
`else
      do_div(8'hF0, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 9, 1'b0);
`endif
      // Flags clear on the next accepted start.
      do_div(8'h0F, 4'h4, 4'h3, 4'h3, 1'b0, 1'b0, 9, 1'b0);

      // Abort in the 4th CALC cycle: no done may follow.
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'h42;
      divisor  = 4'hB;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_quotient", int'(quotient), 0);
      chk("abort_remainder", int'(remainder), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_dbz", int'(div_by_zero), 0);
      chk("abort_ovf", int'(overflow), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("abort_idle", int'(busy), 0);

      do_div(8'h42, 4'hB, 4'h6, 4'h0, 1'b0, 1'b0, 9, 1'b0);
      repeat (12) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
